// File: rtl/binarization_adaptive.sv
// Adaptive pixel binarizer: fixed, window, auto (previous-frame mean) and auto+offset
// threshold modes, with a serial restoring divider that computes the mean during blank.
module binarization_adaptive #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 20,
  parameter int AUTO_INIT = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     per_frame_vsync,
  input  logic                     per_frame_href,
  input  logic                     per_frame_clken,
  input  logic [DATA_W-1:0]        per_img_Y,
  input  logic [DATA_W-1:0]        Binary_Threshold,
  input  logic [DATA_W-1:0]        Binary_Threshold_Hi,
  input  logic [1:0]               mode,
  input  logic signed [DATA_W:0]   Binary_Offset,
  input  logic                     invert,
  output logic                     post_frame_vsync,
  output logic                     post_frame_href,
  output logic                     post_frame_clken,
  output logic                     post_img_Bit,
  output logic [DATA_W-1:0]        auto_threshold,
  output logic                     auto_done
);
  localparam int SUM_W = DATA_W + CNT_W;
  localparam int STEP_W = $clog2(SUM_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0] INIT_THR = DATA_W'(AUTO_INIT);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  // Clamp a widened signed threshold back into the unsigned pixel range.
  function automatic logic [DATA_W-1:0] sat_thr(input logic signed [DATA_W+1:0] v);
    if (v < 0) return '0;
    else if (v > $signed({2'b00, {DATA_W{1'b1}}})) return '1;
    else return v[DATA_W-1:0];
  endfunction

  logic              vsync_q, vsync_d, href_q, href_d, clken_q, clken_d;
  logic              bit_q, bit_d, done_q, done_d;
  logic [DATA_W-1:0] auto_thr_q, auto_thr_d, pending_q, pending_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [SUM_W-1:0]  dvd_q, dvd_d;
  logic [CNT_W-1:0]  rem_q, rem_d, dvs_q, dvs_d;

  logic                     vs_rise, vs_fall, pix_ok, cmp;
  logic [DATA_W-1:0]        thr_auto;
  logic signed [DATA_W+1:0] off_sum;
  logic [CNT_W:0]           rem_sh, rem_sub;

  always_comb begin
    vs_rise  = per_frame_vsync & ~vsync_q;
    vs_fall  = ~per_frame_vsync & vsync_q;
    pix_ok   = per_frame_clken & per_frame_href;
    // The first pixel of a new frame must already see the freshly loaded threshold.
    thr_auto = vs_rise ? pending_q : auto_thr_q;
    off_sum  = $signed({2'b00, thr_auto}) + $signed({Binary_Offset[DATA_W], Binary_Offset});

    cmp = 1'b0;
    case (mode)
      2'd0: cmp = per_img_Y > Binary_Threshold;
      2'd1: cmp = (per_img_Y > Binary_Threshold) && (per_img_Y <= Binary_Threshold_Hi);
      2'd2: cmp = per_img_Y > thr_auto;
      default: cmp = per_img_Y > sat_thr(off_sum);
    endcase

    vsync_d    = per_frame_vsync;
    href_d     = per_frame_href;
    clken_d    = per_frame_clken;
    bit_d      = cmp ^ invert;
    auto_thr_d = auto_thr_q;
    pending_d  = pending_q;
    sum_d      = sum_q;
    count_d    = count_q;
    done_d     = 1'b0;
    state_d    = state_q;
    step_d     = step_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    rem_sh     = {rem_q, dvd_q[SUM_W-1]};
    rem_sub    = rem_sh - {1'b0, dvs_q};

    if (vs_rise) begin
      auto_thr_d = pending_q;
      sum_d      = pix_ok ? SUM_W'(per_img_Y) : '0;
      count_d    = pix_ok ? CNT_W'(1) : '0;
    end else if (pix_ok && per_frame_vsync && count_q != CNT_MAX) begin
      sum_d   = sum_q + SUM_W'(per_img_Y);
      count_d = count_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: if (vs_fall) begin
        dvd_d   = sum_q;
        dvs_d   = count_q;
        rem_d   = '0;
        step_d  = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        // Quotient bits shift into the dividend register as its bits are consumed.
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d = rem_sub[CNT_W-1:0];
          dvd_d = {dvd_q[SUM_W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[CNT_W-1:0];
          dvd_d = {dvd_q[SUM_W-2:0], 1'b0};
        end
        step_d = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) state_d = S_DONE;
      end
      S_DONE: begin
        if (dvs_q != '0) pending_d = dvd_q[DATA_W-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      clken_q    <= 1'b0;
      bit_q      <= 1'b0;
      done_q     <= 1'b0;
      auto_thr_q <= INIT_THR;
      pending_q  <= INIT_THR;
      sum_q      <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      step_q     <= '0;
    end else begin
      vsync_q    <= vsync_d;
      href_q     <= href_d;
      clken_q    <= clken_d;
      bit_q      <= bit_d;
      done_q     <= done_d;
      auto_thr_q <= auto_thr_d;
      pending_q  <= pending_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      state_q    <= state_d;
      step_q     <= step_d;
    end
  end

  // Divider operands carry no control meaning, so they are left unreset.
  always_ff @(posedge clk) begin
    dvd_q <= dvd_d;
    rem_q <= rem_d;
    dvs_q <= dvs_d;
  end

  assign post_frame_vsync = vsync_q;
  assign post_frame_href  = href_q;
  assign post_frame_clken = clken_q;
  assign post_img_Bit     = bit_q;
  assign auto_threshold   = auto_thr_q;
  assign auto_done        = done_q;
endmodule

// File: tb/tb_binarization_adaptive.sv
// Directed bench for binarization_adaptive: compare table plus multi-frame auto-threshold sequences.
module tb_binarization_adaptive;
  logic clk = 1'b0;
  logic rst_n, vsync, href, clken, inv;
  logic [7:0] y, thr, thr_hi;
  logic [1:0] mode;
  logic signed [8:0] off;
  logic post_vsync, post_href, post_clken, post_bit, done;
  logic [7:0] auto_thr;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] pix [0:31];

  always #5 clk = ~clk;

  binarization_adaptive #(.DATA_W(8), .CNT_W(20), .AUTO_INIT(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_Y(y), .Binary_Threshold(thr), .Binary_Threshold_Hi(thr_hi),
    .mode(mode), .Binary_Offset(off), .invert(inv),
    .post_frame_vsync(post_vsync), .post_frame_href(post_href),
    .post_frame_clken(post_clken), .post_img_Bit(post_bit),
    .auto_threshold(auto_thr), .auto_done(done)
  );

  typedef struct packed {
    logic [1:0]        mode;
    logic [7:0]        lo;
    logic [7:0]        hi;
    logic signed [8:0] off;
    logic              inv;
    logic [7:0]        y;
    logic              exp;
  } vec_t;

  vec_t tv [0:21];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vsync = 0; href = 0; clken = 0; y = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  // One frame from pix[0..n-1]; ends on the cycle that presents the vsync falling edge.
  task automatic run_frame(input int n, input bit first_on_rise, input int exp_auto, input int exp_thr);
    int start;
    vsync = 1; href = first_on_rise; clken = first_on_rise;
    y = first_on_rise ? pix[0] : 8'd0;
    step();
    chk("auto_thr_at_rise", auto_thr, exp_auto);
    if (first_on_rise) chk("rise_pixel_bit", post_bit, int'(int'(pix[0]) > exp_thr));
    start = first_on_rise ? 1 : 0;
    for (int i = start; i < n; i++) begin
      href = 1; clken = 1; y = pix[i];
      step();
      chk("frame_bit", post_bit, int'(int'(pix[i]) > exp_thr));
    end
    href = 0; clken = 0; y = 0;
    step();
    chk("auto_thr_in_frame", auto_thr, exp_auto);
    vsync = 0;
    step();
  endtask

  // Waits for auto_done; exp_lat < 0 skips the latency check.
  task automatic wait_done(input int exp_lat);
    int lat = -1;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk("auto_done_timeout", 0, 1);
    else if (exp_lat >= 0) chk("auto_done_latency", lat, exp_lat);
    step();
    chk("auto_done_single_pulse", done, 0);
  endtask

  task automatic no_done(input int n, input string name);
    int seen = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (done === 1'b1) seen = 1;
    end
    chk(name, seen, 0);
  endtask

  function automatic vec_t mk(input int md, input int lo, input int hi, input int of,
                              input int iv, input int yy, input int ex);
    vec_t v;
    v.mode = 2'(md); v.lo = 8'(lo); v.hi = 8'(hi); v.off = 9'(of);
    v.inv = 1'(iv); v.y = 8'(yy); v.exp = 1'(ex);
    return v;
  endfunction

  initial begin
    tv[0]  = mk(0, 100, 0, 0, 0, 98, 0);
    tv[1]  = mk(0, 100, 0, 0, 0, 99, 0);
    tv[2]  = mk(0, 100, 0, 0, 0, 100, 0);
    tv[3]  = mk(0, 100, 0, 0, 0, 101, 1);
    tv[4]  = mk(0, 100, 0, 0, 0, 102, 1);
    tv[5]  = mk(1, 50, 60, 0, 0, 50, 0);
    tv[6]  = mk(1, 50, 60, 0, 0, 51, 1);
    tv[7]  = mk(1, 50, 60, 0, 0, 60, 1);
    tv[8]  = mk(1, 50, 60, 0, 0, 61, 0);
    tv[9]  = mk(1, 60, 50, 0, 0, 55, 0);
    tv[10] = mk(1, 60, 50, 0, 0, 61, 0);
    tv[11] = mk(1, 60, 50, 0, 0, 50, 0);
    tv[12] = mk(1, 50, 60, 0, 1, 50, 1);
    tv[13] = mk(1, 50, 60, 0, 1, 55, 0);
    tv[14] = mk(2, 0, 0, 0, 0, 129, 1);
    tv[15] = mk(2, 0, 0, 0, 0, 128, 0);
    tv[16] = mk(3, 0, 0, 20, 0, 148, 0);
    tv[17] = mk(3, 0, 0, 20, 0, 149, 1);
    tv[18] = mk(3, 0, 0, -200, 0, 0, 0);
    tv[19] = mk(3, 0, 0, -200, 0, 1, 1);
    tv[20] = mk(3, 0, 0, 255, 0, 255, 0);
    tv[21] = mk(0, 255, 0, 0, 1, 255, 1);

    // Reset with every input active so a missing reset would show.
    rst_n = 0; vsync = 1; href = 1; clken = 1; y = 255; thr = 0; thr_hi = 0;
    mode = 0; off = 0; inv = 0;
    step(); step();
    chk("rst_post_vsync", post_vsync, 0);
    chk("rst_post_href", post_href, 0);
    chk("rst_post_clken", post_clken, 0);
    chk("rst_post_bit", post_bit, 0);
    chk("rst_auto_done", done, 0);
    chk("rst_auto_thr", auto_thr, 128);
    vsync = 0; href = 0; clken = 0; y = 0;
    rst_n = 1;
    step();

    for (int i = 0; i < 22; i++) begin
      mode = tv[i].mode; thr = tv[i].lo; thr_hi = tv[i].hi; off = tv[i].off;
      inv = tv[i].inv; y = tv[i].y; href = 1; clken = (i % 3) != 0; vsync = 0;
      step();
      chk($sformatf("vec%0d_bit", i), post_bit, tv[i].exp);
      chk($sformatf("vec%0d_href", i), post_href, 1);
      chk($sformatf("vec%0d_clken", i), post_clken, int'((i % 3) != 0));
      chk($sformatf("vec%0d_vsync", i), post_vsync, 0);
    end
    inv = 0; off = 0; mode = 2;
    idle(3);

    // Auto mode: frame of 16 x 40 with the initial threshold, then adapt.
    for (int i = 0; i < 16; i++) pix[i] = 8'd40;
    run_frame(16, 0, 128, 128);
    wait_done(29);
    idle(3);
    pix[0] = 41; pix[1] = 40; pix[2] = 41;
    run_frame(3, 1, 40, 40);
    wait_done(29);
    idle(3);
    pix[0] = 1; pix[1] = 2; pix[2] = 2;
    run_frame(3, 0, 40, 40);
    wait_done(29);
    idle(3);
    run_frame(0, 0, 1, 1);
    wait_done(29);
    idle(3);
    for (int i = 0; i < 4; i++) pix[i] = 8'd250;
    run_frame(4, 0, 1, 1);
    wait_done(29);
    idle(3);

    // Offset mode saturating high, then low.
    mode = 3; off = 20;
    pix[0] = 255; pix[1] = 5;
    run_frame(2, 0, 250, 255);
    wait_done(29);
    idle(3);
    mode = 2; off = 0;
    for (int i = 0; i < 4; i++) pix[i] = 8'd10;
    run_frame(4, 0, 130, 130);
    wait_done(29);
    idle(3);
    mode = 3; off = -20;
    pix[0] = 1; pix[1] = 0; pix[2] = 1;
    run_frame(3, 0, 10, 0);
    wait_done(29);
    idle(3);

    // Short blanks: adaptation slips one frame, the frame ending mid-division is discarded.
    mode = 2; off = 0;
    for (int i = 0; i < 4; i++) pix[i] = 8'd100;
    run_frame(4, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 30; i++) pix[i] = 8'd200;
    run_frame(30, 0, 0, 0);
    idle(4);
    pix[0] = 150; pix[1] = 150;
    run_frame(2, 0, 100, 100);
    wait_done(-1);
    idle(40);
    pix[0] = 0;
    run_frame(1, 0, 200, 200);
    wait_done(29);
    idle(3);

    // Reset in the middle of a division.
    pix[0] = 50; pix[1] = 50;
    run_frame(2, 0, 0, 0);
    for (int i = 0; i < 10; i++) step();
    rst_n = 0;
    step();
    chk("middiv_rst_auto_thr", auto_thr, 128);
    chk("middiv_rst_done", done, 0);
    chk("middiv_rst_post_bit", post_bit, 0);
    rst_n = 1;
    no_done(40, "middiv_rst_no_done");
    pix[0] = 7;
    run_frame(1, 0, 128, 128);
    wait_done(29);
    idle(3);

    // Reset in the middle of an active frame.
    vsync = 1; href = 1; clken = 1; y = 200;
    step(); step(); step();
    chk("midframe_auto_thr", auto_thr, 7);
    rst_n = 0;
    step();
    chk("midframe_rst_post_vsync", post_vsync, 0);
    chk("midframe_rst_post_href", post_href, 0);
    chk("midframe_rst_post_clken", post_clken, 0);
    chk("midframe_rst_post_bit", post_bit, 0);
    chk("midframe_rst_auto_thr", auto_thr, 128);
    chk("midframe_rst_done", done, 0);
    rst_n = 1; vsync = 0; href = 0; clken = 0; y = 0;
    no_done(35, "midframe_rst_no_done");
    pix[0] = 129;
    run_frame(1, 0, 128, 128);
    wait_done(29);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/binarization_adaptive.md
# binarization_adaptive

Parametrised successor to the fixed-threshold binarizer in the VIP chain: converts a luma/chroma pixel stream to a 1-bit image using one of four threshold modes, including a per-frame automatic threshold equal to the previous frame's mean pixel value. A sequential restoring divider computes the mean during vertical blank. The new threshold is applied only at the next frame start, so the threshold is constant within a frame. It sits between colour-space conversion and the erosion/Sobel/dilation stages, with the same 1-cycle stream latency as the fixed binarizer.

## Interface
- DATA_W, 8: pixel width.
- CNT_W, 20: pixel-counter width. The per-frame count saturates at 2^CNT_W-1.
- AUTO_INIT, 128: auto threshold after reset, before the first computed frame.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- per_frame_vsync  in  1  frame-active; high for the whole frame.
- per_frame_href  in  1  line-active.
- per_frame_clken  in  1  pixel valid.
- per_img_Y  in  DATA_W  pixel value.
- Binary_Threshold  in  DATA_W  fixed or low threshold.
- Binary_Threshold_Hi  in  DATA_W  high threshold (window mode).
- mode  in  2  0 fixed, 1 window, 2 auto, 3 auto+offset.
- Binary_Offset  in  DATA_W+1  signed two's-complement offset for mode 3.
- invert  in  1  invert output bit.
- post_frame_vsync / post_frame_href / post_frame_clken  out  1 each  inputs delayed 1 cycle.
- post_img_Bit  out  1  binarized pixel.
- auto_threshold  out  DATA_W  threshold currently in force for auto modes.
- auto_done  out  1  1-cycle pulse when a new mean has been computed.

## Operation
- Reset (rst_n=0 at a clk edge): all post_* = 0, auto_done = 0, auto_threshold = AUTO_INIT, pending = AUTO_INIT, sum = 0, count = 0, FSM = IDLE. Applies equally mid-frame or mid-division.
- Compare each cycle, registered:
  - mode 0: bit = Y > Binary_Threshold.
  - mode 1: bit = (Y > Binary_Threshold) && (Y <= Binary_Threshold_Hi). If lo >= hi, the bit is always 0.
  - mode 2: bit = Y > auto_threshold.
  - mode 3: bit = Y > clamp(auto_threshold + Binary_Offset, 0, 2^DATA_W-1). Compute at DATA_W+2 bits signed, then saturate.
  - Final bit XORed with invert.
  - mode, thresholds, offset and invert are sampled live; changes are legal at any time and take effect on the next registered pixel.
- Statistics run in every mode:
  - Edge detect uses a registered copy of vsync.
  - Rising edge: sum and count are cleared, and auto_threshold <= pending.
  - If clken && href on the rising-edge cycle, that pixel loads as the first sample: sum = Y, count = 1.
  - Otherwise, each clken && href && vsync: sum += Y, count += 1, unless count is saturated; then both freeze.
  - sum width = DATA_W+CNT_W, so it cannot overflow.
- FSM IDLE -> DIV -> DONE -> IDLE:
  - IDLE: on a vsync falling edge, latch dividend = sum and divisor = count, go to DIV.
  - DIV: restoring division, one quotient bit per cycle, exactly DATA_W+CNT_W cycles.
  - DONE: one cycle. If divisor != 0, pending <= quotient[DATA_W-1:0], which is truncating floor(sum/count) and always < 2^DATA_W. If divisor = 0, pending is unchanged. auto_done = 1 in DONE regardless.
  - A falling edge during DIV/DONE is ignored and that frame's statistics are discarded.
  - A rising edge during DIV does not disturb the division, because its operands are latched.
  - If DONE completes after the rising edge, the result waits in pending until the following frame start.

## Timing
- Stream latency: exactly 1 cycle for vsync/href/clken/Bit, matching the fixed binarizer. Drop-in replacement.
- Falling edge sampled at edge E0. DIV occupies E1..E(DATA_W+CNT_W). auto_done is high for the cycle after edge E(DATA_W+CNT_W+1): 29 cycles after E0 with defaults.
- auto_threshold changes only on a vsync rising-edge cycle, and the first pixel of the frame uses the new value.
- Frame blank must be >= DATA_W+CNT_W+2 cycles for back-to-back frame adaptation. Shorter blank delays adaptation by one frame but stays correct.

## Test plan
- Mode 0, Binary_Threshold=100, Y ramp 98..102 -> Bit 0,0,0,1,1 one cycle after each clken; post_* match inputs delayed by 1.
- Mode 1, lo=50, hi=60, Y=50,51,60,61 -> Bit 0,1,1,0. With lo=60, hi=50, all 0. invert=1 -> complement.
- Mode 2, frame 1 all Y=40 (16 pixels): during frame auto_threshold=128, all Bit 0. auto_done 29 cycles after the falling edge. Frame 2 starts with auto_threshold=40. Y=41 -> 1, Y=40 -> 0.
- Mean truncation: frame of 3 pixels Y=1,2,2 -> pending 1. Frame with zero clken pixels -> auto_done pulses, threshold unchanged.
- Mode 3, auto=250, offset=+20 -> effective 255, Y=255 -> 0. auto=10, offset=-20 -> effective 0, Y=1 -> 1.
- Reset asserted mid-DIV and mid-frame -> next edge all outputs 0, auto_threshold=128, no auto_done. Blank of 5 cycles between frames -> adaptation deferred one frame, no corruption.
